// File: rtl/drive_pkg.sv
// Shared encodings for the collision-aware drive controller: FSM states,
// command opcodes, drive directions and the state-to-output decode helpers.
package drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FWD     = 3'd1,
    ST_REV     = 3'd2,
    ST_BRAKE   = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_FWD  = 2'b01;
  localparam logic [1:0] OP_BWD  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  // Reserved opcode behaves exactly like stop.
  function automatic logic is_stop(input logic [1:0] op);
    return (op == OP_STOP) || (op == OP_RSV);
  endfunction

  function automatic logic ready_of(input state_t s);
    return (s == ST_IDLE) || (s == ST_FWD) || (s == ST_REV);
  endfunction

  function automatic logic en_of(input state_t s);
    return (s == ST_FWD) || (s == ST_REV) || (s == ST_BACKOFF);
  endfunction

  // Direction is only meaningful while the motor is enabled; park it at forward otherwise.
  function automatic logic dir_of(input state_t s, input logic bdir);
    case (s)
      ST_REV:     return DIR_BWD;
      ST_BACKOFF: return bdir;
      default:    return DIR_FWD;
    endcase
  endfunction

endpackage

// File: rtl/collision_drive_ctrl_if.sv
// Drive command handshake: the commander offers an opcode, the controller
// signals when it is willing to take it.
interface collision_drive_ctrl_if;
  import drive_pkg::*;

  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sensor_debounce.sv
// Brings one raw asynchronous contact sensor into the clock domain and only
// accepts a new level after DEB_CYCLES consecutive agreeing samples.
module sensor_debounce
  import drive_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer against metastability on the raw contact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // --- stage boundary: synchronized sample -> debounced level ---
  // Count consecutive samples disagreeing with the accepted level; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_p1 == deb) begin
      cnt <= '0;
    end else if (cnt == DEB_LAST) begin
      cnt <= '0;
      deb <= sync_p1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/collision_drive_ctrl.sv
// Motor drive controller with front/rear collision sensing: brakes on impact,
// backs away from the obstacle, and halts with a sticky fault when boxed in.
module collision_drive_ctrl
  import drive_pkg::*;
#(
  parameter int DEB_CYCLES     = 16,
  parameter int BRAKE_CYCLES   = 1024,
  parameter int BACKOFF_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sens1,
  input  logic                   sens2,
  collision_drive_ctrl_if.slave  cmd,
  output logic                   motor_en,
  output logic                   motor_dir,
  output logic [2:0]             state_o,
  output logic                   fault
);

  localparam int MAX_CYC = (BRAKE_CYCLES > BACKOFF_CYCLES) ? BRAKE_CYCLES : BACKOFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] BRAKE_LAST   = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              bdir;
  logic              bdir_nxt;
  logic              halt_pend;
  logic              halt_pend_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              front;
  logic              rear;
  logic              accept;
  logic              obstacle_ahead;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_front (
    .clk (clk),
    .rst (rst),
    .raw (sens1),
    .deb (front)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rear (
    .clk (clk),
    .rst (rst),
    .raw (sens2),
    .deb (rear)
  );

  assign accept         = cmd.cmd_valid & cmd.cmd_ready;
  assign obstacle_ahead = (bdir == DIR_BWD) ? rear : front;
  assign state_o        = state;

  // Next-state decision; collisions are evaluated before any accepted command.
  always_comb begin
    state_nxt     = state;
    bdir_nxt      = bdir;
    halt_pend_nxt = halt_pend;
    case (state)
      ST_IDLE, ST_FWD, ST_REV: begin
        if ((state != ST_IDLE) && front && rear) begin
          state_nxt     = ST_BRAKE;
          halt_pend_nxt = 1'b1;
        end else if ((state == ST_FWD) && front) begin
          state_nxt     = ST_BRAKE;
          bdir_nxt      = DIR_BWD;
          halt_pend_nxt = 1'b0;
        end else if ((state == ST_REV) && rear) begin
          state_nxt     = ST_BRAKE;
          bdir_nxt      = DIR_FWD;
          halt_pend_nxt = 1'b0;
        end else if (accept) begin
          if (cmd.cmd_op == OP_FWD) begin
            if (!front) state_nxt = ST_FWD;
          end else if (cmd.cmd_op == OP_BWD) begin
            if (!rear) state_nxt = ST_REV;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_BRAKE: begin
        if (cnt == BRAKE_LAST) begin
          state_nxt     = halt_pend ? ST_HALT : ST_BACKOFF;
          halt_pend_nxt = 1'b0;
        end
      end
      ST_BACKOFF: begin
        if (obstacle_ahead)              state_nxt = ST_HALT;
        else if (cnt == BACKOFF_LAST)    state_nxt = ST_IDLE;
      end
      ST_HALT: begin
        // A stop is honoured here even though cmd_ready is low.
        if (cmd.cmd_valid && is_stop(cmd.cmd_op) && !front && !rear) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, phase counter and outputs registered together so outputs track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bdir          <= DIR_FWD;
      halt_pend     <= 1'b0;
      cnt           <= '0;
      cmd.cmd_ready <= 1'b0;
      motor_en      <= 1'b0;
      motor_dir     <= DIR_FWD;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      bdir          <= bdir_nxt;
      halt_pend     <= halt_pend_nxt;
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + CNT_W'(1);
      cmd.cmd_ready <= ready_of(state_nxt);
      motor_en      <= en_of(state_nxt);
      motor_dir     <= dir_of(state_nxt, bdir_nxt);
      fault         <= (state_nxt == ST_HALT);
    end
  end

endmodule

// File: tb/tb_collision_drive_ctrl.sv
// Directed bench for collision_drive_ctrl with DEB_CYCLES=4, BRAKE_CYCLES=8,
// BACKOFF_CYCLES=16. Time reference: after a sensor is raised just past edge
// N, the debounced level appears at edge N+6 and the FSM reacts at edge N+7.
module tb_collision_drive_ctrl;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FWD     = 3'd1;
  localparam logic [2:0] S_REV     = 3'd2;
  localparam logic [2:0] S_BRAKE   = 3'd3;
  localparam logic [2:0] S_BACKOFF = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sens1 = 1'b0;
  logic       sens2 = 1'b0;
  logic       motor_en;
  logic       motor_dir;
  logic       fault;
  logic [2:0] state_o;
  int         errors = 0;
  int         checks = 0;

  collision_drive_ctrl_if cmd_if ();

  collision_drive_ctrl #(
    .DEB_CYCLES     (4),
    .BRAKE_CYCLES   (8),
    .BACKOFF_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sens1     (sens1),
    .sens2     (sens2),
    .cmd       (cmd_if),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .state_o   (state_o),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, S_IDLE); end
    checks++;
    if (motor_en !== 1'b0) begin errors++; $display("FAIL reset_motor_en: got %b want 0", motor_en); end
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_if.cmd_ready); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++;
    rst = 1'b0;
    #1;
    if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", cmd_if.cmd_ready); end
    checks++;
    tick();
    if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge: got %b want 1", cmd_if.cmd_ready); end
    checks++;
  endtask

  task automatic test_forward_collision();
    logic [2:0] exp_st;
    logic       exp_en;
    send_cmd(2'b01);
    if (state_o !== S_FWD) begin errors++; $display("FAIL fwd_enter: got %0d want %0d", state_o, S_FWD); end
    checks++;
    if (motor_dir !== 1'b0) begin errors++; $display("FAIL fwd_dir: got %b want 0", motor_dir); end
    checks++;
    sens1 = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      exp_st = (i <= 6) ? S_FWD : (i <= 14) ? S_BRAKE : (i <= 30) ? S_BACKOFF : S_IDLE;
      exp_en = (exp_st == S_FWD) || (exp_st == S_BACKOFF);
      if (state_o !== exp_st) begin errors++; $display("FAIL coll_state[%0d]: got %0d want %0d", i, state_o, exp_st); end
      checks++;
      if (motor_en !== exp_en) begin errors++; $display("FAIL coll_en[%0d]: got %b want %b", i, motor_en, exp_en); end
      checks++;
      if (exp_st == S_BACKOFF) begin
        if (motor_dir !== 1'b1) begin errors++; $display("FAIL backoff_dir[%0d]: got %b want 1", i, motor_dir); end
        checks++;
      end
      if (i == 7) begin
        if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL brake_ready: got %b want 0", cmd_if.cmd_ready); end
        checks++;
      end
    end
    sens1 = 1'b0;
    tick(8);
  endtask

  task automatic test_collision_priority();
    send_cmd(2'b01);
    sens1 = 1'b1;
    tick(6);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b10;
    tick();
    cmd_if.cmd_valid = 1'b0;
    if (state_o !== S_BRAKE) begin errors++; $display("FAIL prio_state: got %0d want %0d", state_o, S_BRAKE); end
    checks++;
    if (motor_en !== 1'b0) begin errors++; $display("FAIL prio_en: got %b want 0", motor_en); end
    checks++;
    tick(24);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL prio_done: got %0d want %0d", state_o, S_IDLE); end
    checks++;
    sens1 = 1'b0;
    tick(8);
  endtask

  task automatic test_glitch();
    send_cmd(2'b01);
    sens1 = 1'b1;
    tick(3);
    sens1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (state_o !== S_FWD) begin errors++; $display("FAIL glitch_state[%0d]: got %0d want %0d", i, state_o, S_FWD); end
      checks++;
      if (motor_en !== 1'b1) begin errors++; $display("FAIL glitch_en[%0d]: got %b want 1", i, motor_en); end
      checks++;
    end
    send_cmd(2'b00);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL glitch_stop: got %0d want %0d", state_o, S_IDLE); end
    checks++;
  endtask

  task automatic test_double_halt();
    send_cmd(2'b10);
    if (state_o !== S_REV) begin errors++; $display("FAIL rev_enter: got %0d want %0d", state_o, S_REV); end
    checks++;
    if (motor_dir !== 1'b1) begin errors++; $display("FAIL rev_dir: got %b want 1", motor_dir); end
    checks++;
    sens1 = 1'b1;
    sens2 = 1'b1;
    tick(7);
    if (state_o !== S_BRAKE) begin errors++; $display("FAIL dbl_brake_first: got %0d want %0d", state_o, S_BRAKE); end
    checks++;
    tick(7);
    if (state_o !== S_BRAKE) begin errors++; $display("FAIL dbl_brake_last: got %0d want %0d", state_o, S_BRAKE); end
    checks++;
    tick();
    if (state_o !== S_HALT) begin errors++; $display("FAIL dbl_halt: got %0d want %0d", state_o, S_HALT); end
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL dbl_fault: got %b want 1", fault); end
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL halt_ready: got %b want 0", cmd_if.cmd_ready); end
    checks++;
    if (motor_en !== 1'b0) begin errors++; $display("FAIL halt_en: got %b want 0", motor_en); end
    checks++;
    send_cmd(2'b00);
    if (state_o !== S_HALT) begin errors++; $display("FAIL halt_stop_blocked: got %0d want %0d", state_o, S_HALT); end
    checks++;
    sens1 = 1'b0;
    sens2 = 1'b0;
    tick(8);
    if (fault !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", fault); end
    checks++;
    send_cmd(2'b00);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL halt_exit: got %0d want %0d", state_o, S_IDLE); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL halt_fault_clear: got %b want 0", fault); end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL halt_exit_ready: got %b want 1", cmd_if.cmd_ready); end
    checks++;
  endtask

  task automatic test_backoff_cmd();
    send_cmd(2'b01);
    sens1 = 1'b1;
    tick(15);
    if (state_o !== S_BACKOFF) begin errors++; $display("FAIL bo_enter: got %0d want %0d", state_o, S_BACKOFF); end
    checks++;
    sens1 = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b01;
    if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL bo_ready: got %b want 0", cmd_if.cmd_ready); end
    checks++;
    tick();
    cmd_if.cmd_valid = 1'b0;
    if (state_o !== S_BACKOFF) begin errors++; $display("FAIL bo_ignore: got %0d want %0d", state_o, S_BACKOFF); end
    checks++;
    tick(15);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL bo_done: got %0d want %0d", state_o, S_IDLE); end
    checks++;
    sens2 = 1'b1;
    tick(7);
    send_cmd(2'b10);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL bwd_refused: got %0d want %0d", state_o, S_IDLE); end
    checks++;
    sens2 = 1'b0;
    tick(8);
  endtask

  task automatic test_reset_mid_brake();
    send_cmd(2'b01);
    sens1 = 1'b1;
    tick(7);
    if (state_o !== S_BRAKE) begin errors++; $display("FAIL rb_brake: got %0d want %0d", state_o, S_BRAKE); end
    checks++;
    tick(3);
    rst = 1'b1;
    #1;
    if (state_o !== S_IDLE) begin errors++; $display("FAIL rb_state: got %0d want %0d", state_o, S_IDLE); end
    checks++;
    if (motor_en !== 1'b0) begin errors++; $display("FAIL rb_en: got %b want 0", motor_en); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL rb_fault: got %b want 0", fault); end
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL rb_ready: got %b want 0", cmd_if.cmd_ready); end
    checks++;
    sens1 = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
    if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rb_ready_rise: got %b want 1", cmd_if.cmd_ready); end
    checks++;
    send_cmd(2'b01);
    if (state_o !== S_FWD) begin errors++; $display("FAIL rb_new_fwd: got %0d want %0d", state_o, S_FWD); end
    checks++;
    if (motor_en !== 1'b1) begin errors++; $display("FAIL rb_new_en: got %b want 1", motor_en); end
    checks++;
    send_cmd(2'b00);
  endtask

  task automatic test_back_to_back();
    send_cmd(2'b01);
    if (state_o !== S_FWD) begin errors++; $display("FAIL b2b_fwd: got %0d want %0d", state_o, S_FWD); end
    checks++;
    send_cmd(2'b10);
    if (state_o !== S_REV) begin errors++; $display("FAIL b2b_rev: got %0d want %0d", state_o, S_REV); end
    checks++;
    if (motor_dir !== 1'b1) begin errors++; $display("FAIL b2b_rev_dir: got %b want 1", motor_dir); end
    checks++;
    send_cmd(2'b11);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL b2b_rsv_stop: got %0d want %0d", state_o, S_IDLE); end
    checks++;
    if (motor_en !== 1'b0) begin errors++; $display("FAIL b2b_idle_en: got %b want 0", motor_en); end
    checks++;
    send_cmd(2'b10);
    if (state_o !== S_REV) begin errors++; $display("FAIL b2b_rev2: got %0d want %0d", state_o, S_REV); end
    checks++;
    send_cmd(2'b00);
    if (state_o !== S_IDLE) begin errors++; $display("FAIL b2b_stop: got %0d want %0d", state_o, S_IDLE); end
    checks++;
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    test_reset();
    test_forward_collision();
    test_collision_priority();
    test_glitch();
    test_double_halt();
    test_backoff_cmd();
    test_reset_mid_brake();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/collision_drive_ctrl.md
COLLISION_DRIVE_CTRL -- requirements
Module: collision_drive_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, 16, consecutive synchronized samples required to accept a sensor level change.
REQ-002 Parameter BRAKE_CYCLES, 1024, cycles the motor is held off after a collision.
REQ-003 Parameter BACKOFF_CYCLES, 4096, cycles driven away from the obstacle after braking.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous and active-high.
REQ-006 Port sens1  in  1  front collision sensor, raw, asynchronous, 1 = contact.
REQ-007 Port sens2  in  1  rear collision sensor, raw, asynchronous, 1 = contact.
REQ-008 Port cmd_valid  in  1  drive command offered.
REQ-009 Port cmd_op  in  2  00 stop, 01 forward, 10 backward, 11 reserved (treated as stop).
REQ-010 Port cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready.
REQ-011 Port motor_en  out  1  motor enable.
REQ-012 Port motor_dir  out  1  0 forward, 1 backward; don't-care when motor_en = 0.
REQ-013 Port state_o  out  3  current FSM state encoding.
REQ-014 Port fault  out  1  sticky: both sensors hit, or obstacle struck during backoff.

Function
REQ-015 Each sensor SHALL pass a 2-flop synchronizer, then a debouncer whose output changes only after DEB_CYCLES consecutive equal synchronized samples; latency raw->debounced = 2 + DEB_CYCLES cycles.
REQ-016 FSM states SHALL be IDLE, FWD, REV, BRAKE, BACKOFF, HALT.
REQ-017 cmd_ready SHALL be 1 in IDLE, FWD, REV and 0 in BRAKE, BACKOFF, HALT; unaccepted commands are dropped, not queued.
REQ-018 Accepted command: forward -> FWD, backward -> REV, stop/reserved -> IDLE, on the next edge.
REQ-019 Forward command SHALL be refused (state unchanged) while debounced front = 1; backward likewise while debounced rear = 1.
REQ-020 FWD with debounced front = 1 -> BRAKE, backoff direction = backward; REV with debounced rear = 1 -> BRAKE, backoff direction = forward; transition on the edge after the debounced rise.
REQ-021 Collision SHALL take priority over a command accepted in the same cycle.
REQ-022 Both debounced sensors = 1 in FWD or REV -> BRAKE then HALT, fault set.
REQ-023 BRAKE lasts exactly BRAKE_CYCLES cycles, then -> BACKOFF (or HALT per REQ-022).
REQ-024 BACKOFF lasts exactly BACKOFF_CYCLES cycles, then -> IDLE; debounced sensor in backoff direction = 1 -> HALT, fault set.
REQ-025 HALT SHALL exit to IDLE only on a stop command, accepted despite cmd_ready = 0, and only when both debounced sensors = 0; fault clears on that exit.
REQ-026 Outputs decoded from the state register: motor_en = 1 in FWD, REV, BACKOFF only; motor_dir = 0 in FWD, 1 in REV, backoff direction in BACKOFF.
REQ-027 Phase counter width = clog2(max(BRAKE_CYCLES, BACKOFF_CYCLES)) + 1; cleared on every state entry; no wrap.

Reset
REQ-028 rst SHALL asynchronously force IDLE, motor_en = 0, motor_dir = 0, cmd_ready = 0, fault = 0, counters and debounced levels = 0, including mid-BRAKE/BACKOFF.
REQ-029 cmd_ready SHALL rise on the first edge after rst deasserts.

Structure
REQ-030 State encoding, cmd_op codes and direction constants SHALL live in shared package drive_pkg.
REQ-031 Debounce SHALL be sub-module sensor_debounce (synchronizer + counter), instantiated twice.

Verification (DEB_CYCLES=4, BRAKE_CYCLES=8, BACKOFF_CYCLES=16)
REQ-032 Forward cmd, sens1 held high at cycle 20 -> BRAKE at cycle 27, motor_en 0 for 8 cycles, motor_dir 1 for 16 cycles, IDLE at cycle 51.
REQ-033 sens1 pulsed high 3 cycles in FWD -> no state change, motor_en stays 1.
REQ-034 sens1 and sens2 rise together in REV -> BRAKE 8 cycles, HALT, fault = 1; stop cmd with sensors low -> IDLE, fault = 0.
REQ-035 Forward cmd during BACKOFF -> cmd_ready 0, ignored; backward cmd while debounced rear = 1 -> refused, state IDLE.
REQ-036 rst asserted at cycle 3 of BRAKE -> immediate IDLE, motor_en 0, fault 0; new forward cmd accepted after release.
